// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types, fetch FSM states and the canonical NOP encoding.
package riscv_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] instr_t;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} fetch_state_t;
  localparam instr_t RV_NOP = 32'h0000_0013;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/response bus between fetch stage and memory.
interface if_stage_if;
  import riscv_pkg::*;
  logic ImemReq;
  addr_t ImemAddr;
  logic ImemGnt;
  logic ImemRValid;
  instr_t ImemRData;
  modport master(output ImemReq, ImemAddr, input ImemGnt, ImemRValid, ImemRData);
  modport slave(input ImemReq, ImemAddr, output ImemGnt, ImemRValid, ImemRData);
endinterface

// File: rtl/if_stage.sv
// if_stage: single-outstanding instruction fetch with stall hold and redirect flush.
module if_stage
  import riscv_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0000_0000,
  parameter instr_t NOP_INSTR = RV_NOP
) (
  input logic clk,
  input logic reset,
  input logic StallF,
  input logic RedirectE,
  input addr_t PCTargetE,
  if_stage_if.master imem,
  output instr_t InstrF,
  output addr_t PCF,
  output addr_t PCPlus4F,
  output logic ValidF
);
  fetch_state_t state;
  addr_t pc;
  assign imem.ImemReq = state == S_REQ;
  assign imem.ImemAddr = pc;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      ValidF <= 1'b0;
      InstrF <= NOP_INSTR;
      PCF <= RESET_PC;
      PCPlus4F <= RESET_PC + 32'd4;
    end else if (RedirectE) begin
      pc <= PCTargetE & ~32'h3;
      // a granted or still-pending request must have its response swallowed
      state <= (state == S_REQ && imem.ImemGnt) ||
               ((state == S_WAIT || state == S_DROP) && !imem.ImemRValid) ? S_DROP : S_REQ;
      if (state == S_HOLD) begin
        ValidF <= 1'b0;
        InstrF <= NOP_INSTR;
      end
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: state <= imem.ImemGnt ? S_WAIT : S_REQ;
        S_WAIT:
          if (imem.ImemRValid) begin
            InstrF <= imem.ImemRData;
            PCF <= pc;
            PCPlus4F <= pc + 32'd4;
            ValidF <= 1'b1;
            state <= S_HOLD;
          end
        S_HOLD:
          if (!StallF) begin
            pc <= pc + 32'd4;
            ValidF <= 1'b0;
            InstrF <= NOP_INSTR;
            state <= S_REQ;
          end
        S_DROP: state <= imem.ImemRValid ? S_REQ : S_DROP;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of the fetch stage against a small memory model.
module tb_if_stage;
  logic clk = 0, reset = 0, StallF = 0, RedirectE = 0;
  logic [31:0] PCTargetE = 0;
  logic [31:0] InstrF, PCF, PCPlus4F, instr2, pcf2, pcp42;
  logic ValidF, valid2;
  int checks = 0, errors = 0;
  if_stage_if bus();
  if_stage_if bus2();
  if_stage dut (.clk(clk), .reset(reset), .StallF(StallF), .RedirectE(RedirectE), .PCTargetE(PCTargetE),
    .imem(bus), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF));
  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .reset(reset), .StallF(StallF), .RedirectE(1'b0),
    .PCTargetE(32'h0), .imem(bus2), .InstrF(instr2), .PCF(pcf2), .PCPlus4F(pcp42), .ValidF(valid2));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic test_reset();
    reset = 0;
    tick();
    tick();
    checks++; if (ValidF !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", ValidF); end
    checks++; if (InstrF !== 32'h13) begin errors++; $display("FAIL reset_instr got %h exp 00000013", InstrF); end
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf got %h exp 0", PCF); end
    checks++; if (PCPlus4F !== 32'h4) begin errors++; $display("FAIL reset_pcp4 got %h exp 4", PCPlus4F); end
    checks++; if (bus.ImemReq !== 1'b0) begin errors++; $display("FAIL reset_req got %h exp 0", bus.ImemReq); end
    checks++; if (pcf2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset2_pcf got %h exp fffffffc", pcf2); end
    checks++; if (pcp42 !== 32'h0) begin errors++; $display("FAIL reset2_pcp4 got %h exp 0", pcp42); end
  endtask

  task automatic test_fetch();
    bus.ImemGnt = 1;
    reset = 1;
    tick();
    checks++; if (bus.ImemReq !== 1'b1) begin errors++; $display("FAIL fetch_req got %h exp 1", bus.ImemReq); end
    checks++; if (bus.ImemAddr !== 32'h0) begin errors++; $display("FAIL fetch_addr got %h exp 0", bus.ImemAddr); end
    tick();
    checks++; if (bus.ImemReq !== 1'b0) begin errors++; $display("FAIL fetch_wait_req got %h exp 0", bus.ImemReq); end
    checks++; if (ValidF !== 1'b0) begin errors++; $display("FAIL fetch_early_valid got %h exp 0", ValidF); end
    bus.ImemRValid = 1;
    bus.ImemRData = 32'h0050_0093;
    StallF = 1;
    tick();
    bus.ImemRValid = 0;
    checks++; if (ValidF !== 1'b1) begin errors++; $display("FAIL fetch_valid got %h exp 1", ValidF); end
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL fetch_pcf got %h exp 0", PCF); end
    checks++; if (PCPlus4F !== 32'h4) begin errors++; $display("FAIL fetch_pcp4 got %h exp 4", PCPlus4F); end
    checks++; if (InstrF !== 32'h0050_0093) begin errors++; $display("FAIL fetch_instr got %h exp 00500093", InstrF); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (ValidF !== 1'b1) begin errors++; $display("FAIL stall_valid got %h exp 1", ValidF); end
      checks++; if (InstrF !== 32'h0050_0093) begin errors++; $display("FAIL stall_instr got %h exp 00500093", InstrF); end
      checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL stall_pcf got %h exp 0", PCF); end
      checks++; if (bus.ImemReq !== 1'b0) begin errors++; $display("FAIL stall_req got %h exp 0", bus.ImemReq); end
    end
    StallF = 0;
    tick();
    checks++; if (ValidF !== 1'b0) begin errors++; $display("FAIL consume_valid got %h exp 0", ValidF); end
    checks++; if (InstrF !== 32'h13) begin errors++; $display("FAIL consume_instr got %h exp 00000013", InstrF); end
    checks++; if (bus.ImemReq !== 1'b1) begin errors++; $display("FAIL consume_req got %h exp 1", bus.ImemReq); end
    checks++; if (bus.ImemAddr !== 32'h4) begin errors++; $display("FAIL consume_addr got %h exp 4", bus.ImemAddr); end
  endtask

  task automatic test_redirect_wait();
    tick();
    RedirectE = 1;
    PCTargetE = 32'h0000_0102;
    tick();
    RedirectE = 0;
    checks++; if (bus.ImemReq !== 1'b0) begin errors++; $display("FAIL drop_req got %h exp 0", bus.ImemReq); end
    bus.ImemRValid = 1;
    bus.ImemRData = 32'hDEAD_BEEF;
    tick();
    bus.ImemRValid = 0;
    checks++; if (ValidF !== 1'b0) begin errors++; $display("FAIL drop_valid got %h exp 0", ValidF); end
    checks++; if (bus.ImemReq !== 1'b1) begin errors++; $display("FAIL drop_done_req got %h exp 1", bus.ImemReq); end
    checks++; if (bus.ImemAddr !== 32'h100) begin errors++; $display("FAIL drop_addr got %h exp 00000100", bus.ImemAddr); end
    tick();
    RedirectE = 1;
    PCTargetE = 32'h0000_0200;
    bus.ImemRValid = 1;
    tick();
    RedirectE = 0;
    bus.ImemRValid = 0;
    checks++; if (ValidF !== 1'b0) begin errors++; $display("FAIL wait_rv_redir_valid got %h exp 0", ValidF); end
    checks++; if (bus.ImemReq !== 1'b1) begin errors++; $display("FAIL wait_rv_redir_req got %h exp 1", bus.ImemReq); end
    checks++; if (bus.ImemAddr !== 32'h200) begin errors++; $display("FAIL wait_rv_redir_addr got %h exp 00000200", bus.ImemAddr); end
  endtask

  task automatic test_redirect_hold();
    tick();
    bus.ImemRValid = 1;
    bus.ImemRData = 32'h1111_1111;
    tick();
    bus.ImemRValid = 0;
    checks++; if (PCF !== 32'h200) begin errors++; $display("FAIL hold_pcf got %h exp 00000200", PCF); end
    checks++; if (InstrF !== 32'h1111_1111) begin errors++; $display("FAIL hold_instr got %h exp 11111111", InstrF); end
    StallF = 1;
    RedirectE = 1;
    PCTargetE = 32'h0000_0300;
    tick();
    RedirectE = 0;
    StallF = 0;
    checks++; if (ValidF !== 1'b0) begin errors++; $display("FAIL flush_valid got %h exp 0", ValidF); end
    checks++; if (InstrF !== 32'h13) begin errors++; $display("FAIL flush_instr got %h exp 00000013", InstrF); end
    checks++; if (bus.ImemReq !== 1'b1) begin errors++; $display("FAIL flush_req got %h exp 1", bus.ImemReq); end
    checks++; if (bus.ImemAddr !== 32'h300) begin errors++; $display("FAIL flush_addr got %h exp 00000300", bus.ImemAddr); end
  endtask

  task automatic test_redirect_req();
    bus.ImemGnt = 0;
    RedirectE = 1;
    PCTargetE = 32'h0000_0404;
    tick();
    RedirectE = 0;
    checks++; if (bus.ImemReq !== 1'b1) begin errors++; $display("FAIL req_redir_req got %h exp 1", bus.ImemReq); end
    checks++; if (bus.ImemAddr !== 32'h404) begin errors++; $display("FAIL req_redir_addr got %h exp 00000404", bus.ImemAddr); end
    bus.ImemRValid = 1;
    tick();
    bus.ImemRValid = 0;
    checks++; if (ValidF !== 1'b0) begin errors++; $display("FAIL stray_rv_valid got %h exp 0", ValidF); end
    checks++; if (bus.ImemReq !== 1'b1) begin errors++; $display("FAIL stray_rv_req got %h exp 1", bus.ImemReq); end
    RedirectE = 1;
    PCTargetE = 32'h0000_0500;
    bus.ImemGnt = 1;
    tick();
    RedirectE = 0;
    bus.ImemGnt = 0;
    checks++; if (bus.ImemReq !== 1'b0) begin errors++; $display("FAIL gnt_redir_req got %h exp 0", bus.ImemReq); end
    checks++; if (bus.ImemAddr !== 32'h500) begin errors++; $display("FAIL gnt_redir_addr got %h exp 00000500", bus.ImemAddr); end
    tick();
    checks++; if (bus.ImemReq !== 1'b0) begin errors++; $display("FAIL drop_hold_req got %h exp 0", bus.ImemReq); end
    bus.ImemRValid = 1;
    tick();
    bus.ImemRValid = 0;
    checks++; if (bus.ImemReq !== 1'b1) begin errors++; $display("FAIL drop_exit_req got %h exp 1", bus.ImemReq); end
    checks++; if (ValidF !== 1'b0) begin errors++; $display("FAIL drop_exit_valid got %h exp 0", ValidF); end
  endtask

  task automatic test_wrap();
    reset = 0;
    tick();
    reset = 1;
    bus2.ImemGnt = 1;
    tick();
    checks++; if (bus2.ImemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", bus2.ImemAddr); end
    tick();
    bus2.ImemRValid = 1;
    bus2.ImemRData = 32'h00A0_0113;
    tick();
    bus2.ImemRValid = 0;
    bus2.ImemGnt = 0;
    checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL wrap_valid got %h exp 1", valid2); end
    checks++; if (pcf2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pcf got %h exp fffffffc", pcf2); end
    checks++; if (pcp42 !== 32'h0) begin errors++; $display("FAIL wrap_pcp4 got %h exp 0", pcp42); end
    tick();
    checks++; if (bus2.ImemAddr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got %h exp 0", bus2.ImemAddr); end
    checks++; if (bus2.ImemReq !== 1'b1) begin errors++; $display("FAIL wrap_next_req got %h exp 1", bus2.ImemReq); end
  endtask

  task automatic test_reset_mid();
    bus.ImemGnt = 1;
    tick();
    checks++; if (bus.ImemReq !== 1'b0) begin errors++; $display("FAIL mid_wait_req got %h exp 0", bus.ImemReq); end
    reset = 0;
    bus.ImemGnt = 0;
    tick();
    reset = 1;
    checks++; if (bus.ImemReq !== 1'b0) begin errors++; $display("FAIL mid_reset_req got %h exp 0", bus.ImemReq); end
    bus.ImemRValid = 1;
    bus.ImemRData = 32'hBAD0_BAD0;
    tick();
    bus.ImemRValid = 0;
    checks++; if (ValidF !== 1'b0) begin errors++; $display("FAIL late_rv_valid got %h exp 0", ValidF); end
    checks++; if (bus.ImemReq !== 1'b1) begin errors++; $display("FAIL late_rv_req got %h exp 1", bus.ImemReq); end
    checks++; if (bus.ImemAddr !== 32'h0) begin errors++; $display("FAIL late_rv_addr got %h exp 0", bus.ImemAddr); end
  endtask

  task automatic test_random();
    logic pending, prev_valid, gnt, rv, stall, redir, s_valid;
    logic [31:0] pend_addr, exp_pc, tgt, s_addr;
    int rcnt, gcnt, fetched;
    pending = 0; prev_valid = 0; exp_pc = 0; rcnt = 0; gcnt = 0; fetched = 0; pend_addr = 0;
    bus.ImemGnt = 0; bus.ImemRValid = 0; StallF = 0; RedirectE = 0;
    reset = 0;
    tick();
    reset = 1;
    for (int c = 0; c < 3000; c++) begin
      if (ValidF && !prev_valid) begin
        fetched++;
        checks++; if (PCF !== exp_pc) begin errors++; $display("FAIL rnd_pcf got %h exp %h", PCF, exp_pc); end
        checks++; if (InstrF !== mem_data(exp_pc)) begin errors++; $display("FAIL rnd_instr got %h exp %h", InstrF, mem_data(exp_pc)); end
        checks++; if (PCPlus4F !== exp_pc + 32'd4) begin errors++; $display("FAIL rnd_pcp4 got %h exp %h", PCPlus4F, exp_pc + 32'd4); end
      end
      if (bus.ImemReq) begin
        checks++; if (bus.ImemAddr !== exp_pc) begin errors++; $display("FAIL rnd_addr got %h exp %h", bus.ImemAddr, exp_pc); end
      end
      stall = ($urandom % 3) == 0;
      redir = ($urandom % 10) == 0;
      tgt = $urandom;
      gnt = 0;
      if (bus.ImemReq && !pending) begin
        if (gcnt == 0) gnt = 1; else gcnt--;
      end
      rv = 0;
      if (pending) begin
        if (rcnt == 0) rv = 1; else rcnt--;
      end
      bus.ImemGnt = gnt;
      bus.ImemRValid = rv;
      bus.ImemRData = rv ? mem_data(pend_addr) : $urandom;
      StallF = stall;
      RedirectE = redir;
      PCTargetE = tgt;
      s_addr = bus.ImemAddr;
      s_valid = ValidF;
      prev_valid = ValidF;
      tick();
      if (gnt) begin
        pending = 1;
        pend_addr = s_addr;
        rcnt = $urandom_range(0, 4);
        gcnt = $urandom_range(0, 4);
      end
      if (rv) pending = 0;
      if (redir) exp_pc = tgt & ~32'h3;
      else if (s_valid && !stall) exp_pc = exp_pc + 32'd4;
    end
    RedirectE = 0; StallF = 0; bus.ImemGnt = 0; bus.ImemRValid = 0;
    checks++; if (fetched < 20) begin errors++; $display("FAIL rnd_progress got %0d exp >=20", fetched); end
  endtask

  initial begin
    bus.ImemGnt = 0; bus.ImemRValid = 0; bus.ImemRData = 0;
    bus2.ImemGnt = 0; bus2.ImemRValid = 0; bus2.ImemRData = 0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_req();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: InstrF value while no valid instruction is held.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 Port StallF, input, 1: downstream IF/ID register cannot accept; the held instruction stays held.
REQ-006 Port RedirectE, input, 1: taken branch or jump; fetch resumes at PCTargetE.
REQ-007 Port PCTargetE, input, 32: redirect target address.
REQ-008 Port ImemReq, output, 1: instruction-memory request valid.
REQ-009 Port ImemAddr, output, 32: request address; equals the PC register.
REQ-010 Port ImemGnt, input, 1: memory accepted the request this cycle.
REQ-011 Port ImemRValid, input, 1: read data valid this cycle.
REQ-012 Port ImemRData, input, 32: read data.
REQ-013 Ports InstrF, PCF and PCPlus4F, output, 32 each: held instruction, its PC, and its PC+4, feeding IF/ID.
REQ-014 Port ValidF, output, 1: InstrF, PCF and PCPlus4F hold a valid fetched instruction.

Function
REQ-015 FSM states: IDLE, REQ, WAIT, HOLD, DROP; at most one memory request outstanding.
REQ-016 IDLE: ImemReq=0; next state REQ unconditionally.
REQ-017 REQ: ImemReq=1 and ImemAddr=PC, held stable until grant; on ImemGnt=1, next state WAIT.
REQ-018 WAIT: on ImemRValid=1, capture InstrF<=ImemRData, PCF<=PC, PCPlus4F<=PC+4, ValidF<=1; next state HOLD.
REQ-019 HOLD: ValidF=1 and ImemReq=0; if StallF=1, all outputs hold; if StallF=0, the instruction is consumed: PC<=PC+4, ValidF<=0, InstrF<=NOP_INSTR, next state REQ.
REQ-020 Redirect has priority over grant, data and StallF in every state; PC<=PCTargetE with bits [1:0] forced to 0.
REQ-021 Redirect in REQ without grant: request withdrawn, PC updated, state stays REQ; the new address is presented the next cycle.
REQ-022 Redirect in REQ with grant, or in WAIT without ImemRValid: next state DROP.
REQ-023 Redirect in WAIT with ImemRValid: data discarded, nothing captured, next state REQ.
REQ-024 Redirect in HOLD: ValidF<=0 and InstrF<=NOP_INSTR (flush), even when StallF=1; next state REQ.
REQ-025 DROP: ImemReq=0; the next ImemRValid is discarded, then next state REQ; a further redirect in DROP updates PC only.
REQ-026 PC+4 arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
REQ-027 Minimum latency: grant in cycle N and ImemRValid in N+1 give ValidF=1 in N+2.
REQ-028 ImemRValid outside WAIT or DROP and ImemGnt outside REQ are ignored.

Reset
REQ-029 When reset=0 at a clk edge: PC<=RESET_PC, state<=IDLE, ValidF<=0, ImemReq=0, InstrF<=NOP_INSTR, PCF<=RESET_PC, PCPlus4F<=RESET_PC+4.
REQ-030 Reset mid-transaction abandons any outstanding request; a late ImemRValid after reset is ignored per REQ-028.

Structure
REQ-031 The shared package riscv_pkg holds the fetch-state enum, the NOP_INSTR constant and the 32-bit address/instruction typedefs.
REQ-032 Single module with no sub-modules; the PC register and FSM are local.

Verification
REQ-033 Reset release, ImemGnt tied to 1, ImemRValid one cycle after grant, data 32'h0050_0093 -> ValidF=1 at cycle 3, PCF=0, PCPlus4F=4, InstrF=32'h0050_0093.
REQ-034 StallF=1 for 5 cycles in HOLD -> outputs stable and ImemReq=0; after StallF drops, next ImemAddr=4.
REQ-035 RedirectE=1 with PCTargetE=32'h0000_0102 in WAIT, ImemRValid the following cycle -> data dropped, ValidF stays 0, next ImemAddr=32'h0000_0100.
REQ-036 RedirectE=1 with StallF=1 in HOLD -> ValidF=0 and InstrF=32'h0000_0013 next cycle, ImemAddr=target.
REQ-037 RESET_PC=32'hFFFF_FFFC, one instruction consumed -> PCPlus4F=0 and next ImemAddr=0.
REQ-038 Random ImemGnt/ImemRValid delays of 0-4 cycles with random redirects -> no instruction from a pre-redirect address ever has ValidF=1, and fetched PCs are strictly sequential between redirects.
